// File: rtl/uk101_pkg.sv
// Shared types and character constants for the UK101 text feeder path.
package uk101_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    PRESENT,
    GAP
  } tf_state_t;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_EOF = 8'h1A;

  localparam int TF_GAP_W = 23;

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port byte buffer: ioctl write port, one-cycle registered read port.
module text_buffer_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rd_data_q;

  // No reset so the array and read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/text_feeder.sv
// Captures an ASCII download into a buffer, then replays it paced to the ACIA Rx path.
//   state   | meaning
//   IDLE    | feeder inactive, waiting for a download to start
//   LOAD    | download running, bytes captured into the buffer
//   FETCH   | read byte at ptr (two cycles: issue, then inspect)
//   PRESENT | rx_data/rx_valid held until the ACIA acknowledges
//   GAP     | pacing delay before the next fetch
module text_feeder
  import uk101_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int CHAR_GAP = 50000,
  parameter int CR_GAP   = 5000000
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              abort,
  input  logic              rx_ack,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              active
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [TF_GAP_W-1:0] CHAR_GAP_C = TF_GAP_W'(CHAR_GAP);
  localparam logic [TF_GAP_W-1:0] CR_GAP_C   = TF_GAP_W'(CR_GAP);

  tf_state_t            state_q, state_d;
  logic                 dl_q;
  logic [LEN_W-1:0]     length_q, length_d;
  logic [LEN_W-1:0]     ptr_q, ptr_d;
  logic [TF_GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 pend_q, pend_d;

  logic                 dl_rise, dl_fall;
  logic                 ram_we, ram_re;
  logic [LEN_W-1:0]     wr_end;
  logic [LEN_W-1:0]     ptr_next;
  logic [7:0]           rd_data;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign ram_we   = ioctl_download & ioctl_wr;
  assign ram_re   = (state_q == FETCH) & ~pend_q;
  assign wr_end   = {1'b0, ioctl_addr} + LEN_W'(1);
  assign ptr_next = ptr_q + LEN_W'(1);

  text_buffer_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ioctl_addr),
    .wr_data (ioctl_data),
    .rd_en   (ram_re),
    .rd_addr (ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // A new download always starts from an empty buffer, even if it interrupts a replay.
  always_comb begin
    length_d = dl_rise ? '0 : length_q;
    if (ram_we && (wr_end > length_d)) length_d = wr_end;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gap_d      = gap_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    pend_d     = 1'b0;

    if (dl_rise) begin
      state_d    = LOAD;
      rx_valid_d = 1'b0;
    end else if (abort) begin
      state_d    = IDLE;
      rx_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (dl_fall) begin
            if (length_q == '0) begin
              state_d = IDLE;
            end else begin
              ptr_d   = '0;
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          if (!pend_q) begin
            pend_d = 1'b1;
          end else if (rd_data == ASCII_LF) begin
            // A trailing LF must not walk the pointer past the end of the text.
            if (ptr_next == length_q) state_d = IDLE;
            else                      ptr_d   = ptr_next;
          end else if (rd_data == ASCII_EOF) begin
            state_d = IDLE;
          end else begin
            rx_data_d  = rd_data;
            rx_valid_d = 1'b1;
            state_d    = PRESENT;
          end
        end
        PRESENT: begin
          if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            ptr_d      = ptr_next;
            gap_d      = (rx_data_q == ASCII_CR) ? CR_GAP_C : CHAR_GAP_C;
            state_d    = GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) state_d = (ptr_q == length_q) ? IDLE : FETCH;
          else             gap_d   = gap_q - TF_GAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      length_q   <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      length_q   <= length_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pend_q     <= pend_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign active   = (state_q == FETCH) || (state_q == PRESENT) || (state_q == GAP);

endmodule

// File: tb/tb_text_feeder.sv
// Scenario bench for text_feeder: downloads text, acknowledges replayed characters, checks order and pacing.
module tb_text_feeder;

  localparam int ADDR_W   = 13;
  localparam int CHAR_GAP = 1;
  localparam int CR_GAP   = 30;
  localparam int DEPTH    = 2**ADDR_W;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              n_reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [ADDR_W-1:0] ioctl_addr = '0;
  logic [7:0]        ioctl_data = 8'h00;
  logic              abort = 1'b0;
  logic              rx_ack = 1'b0;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              active;

  int   checks = 0;
  int   failures = 0;
  bq_t  exp_q;
  bq_t  got_q;
  int   gap_q[$];
  int   bad_clear;
  bit   timed_out;

  text_feeder #(
    .ADDR_W   (ADDR_W),
    .CHAR_GAP (CHAR_GAP),
    .CR_GAP   (CR_GAP)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .abort          (abort),
    .rx_ack         (rx_ack),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .active         (active)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Writes bytes from address 0 and pushes what the replay should present.
  task automatic download(input bq_t bytes_in);
    bit eof;
    eof = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < bytes_in.size(); i++) begin
      ioctl_wr = 1'b1; ioctl_addr = ADDR_W'(i); ioctl_data = bytes_in[i];
      tick();
      if (!eof) begin
        if (bytes_in[i] == 8'h1A)      eof = 1'b1;
        else if (bytes_in[i] != 8'h0A) exp_q.push_back(bytes_in[i]);
      end
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
  endtask

  // Acknowledges every presented char ack_dly cycles after it appears; records chars
  // and the cycle count from each ack edge to the next rx_valid rise or to active falling.
  task automatic collect(input int ack_dly, input int budget);
    int cyc;
    int k;
    got_q.delete(); gap_q.delete();
    bad_clear = 0; timed_out = 1'b0; cyc = 0;
    while (!active && cyc < budget) begin tick(); cyc++; end
    while (cyc < budget) begin
      while (!rx_valid && active && cyc < budget) begin tick(); cyc++; end
      if (!active || cyc >= budget) break;
      got_q.push_back(rx_data);
      repeat (ack_dly) begin tick(); cyc++; end
      rx_ack = 1'b1; tick(); cyc++; rx_ack = 1'b0;
      if (rx_valid !== 1'b0) bad_clear++;
      k = 0;
      while (!rx_valid && active && cyc < budget) begin tick(); k++; cyc++; end
      gap_q.push_back(k);
    end
    if (active) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    #2 n_reset = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%0h exp=0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
    checks++; if (active !== 1'b0)   begin failures++; $display("FAIL reset_active got=%0b exp=0", active); end
    tick(); tick();
    #2 n_reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n_exp;
    logic [7:0] g, e;
    exp_q.delete();
    download(str2q("10 A=1\r\n"));
    n_exp = exp_q.size();
    collect(5, 2000);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=active exp=idle"); end
    checks++; if (got_q.size() != 7 || n_exp != 7) begin failures++; $display("FAIL basic_count got=%0d exp=7", got_q.size()); end
    for (int i = 0; i < gap_q.size(); i++) begin
      checks++;
      if (gap_q[i] != ((i == 6) ? CR_GAP + 3 : CHAR_GAP + 3)) begin
        failures++; $display("FAIL basic_gap%0d got=%0d exp=%0d", i, gap_q[i], (i == 6) ? CR_GAP + 3 : CHAR_GAP + 3);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL basic_char got=%0h exp=%0h", g, e); end
    end
    checks++; if (bad_clear != 0) begin failures++; $display("FAIL basic_valid_clear got=%0d exp=0", bad_clear); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL basic_end_active got=%0b exp=0", active); end
  endtask

  task automatic test_eof();
    bq_t q;
    logic [7:0] g, e;
    exp_q.delete();
    q = str2q("AB"); q.push_back(8'h1A); q.push_back(8'h43); q.push_back(8'h44);
    download(q);
    collect(2, 1000);
    checks++; if (timed_out) begin failures++; $display("FAIL eof_timeout got=active exp=idle"); end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL eof_count got=%0d exp=2", got_q.size()); end
    checks++; if (gap_q.size() != 2 || gap_q[1] != CHAR_GAP + 3) begin
      failures++; $display("FAIL eof_stop_time got=%0d exp=%0d", (gap_q.size() == 2) ? gap_q[1] : -1, CHAR_GAP + 3);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL eof_char got=%0h exp=%0h", g, e); end
    end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL eof_active got=%0b exp=0", active); end
  endtask

  task automatic test_empty();
    bit seen_valid, seen_active;
    seen_valid = 1'b0; seen_active = 1'b0;
    ioctl_download = 1'b1;
    repeat (3) tick();
    ioctl_download = 1'b0;
    repeat (20) begin
      tick();
      seen_valid  |= rx_valid;
      seen_active |= active;
    end
    checks++; if (seen_valid)  begin failures++; $display("FAIL empty_valid got=1 exp=0"); end
    checks++; if (seen_active) begin failures++; $display("FAIL empty_active got=1 exp=0"); end
  endtask

  task automatic test_abort();
    int n, cyc;
    bit hit;
    logic [7:0] g, e;
    exp_q.delete(); got_q.delete();
    download(str2q("ABCDE"));
    n = 0; cyc = 0; hit = 1'b0;
    while (cyc < 500 && !hit) begin
      if (rx_valid) begin
        if (n == 2) hit = 1'b1;
        else begin
          got_q.push_back(rx_data); n++;
          rx_ack = 1'b1; tick(); rx_ack = 1'b0; cyc++;
        end
      end else begin
        tick(); cyc++;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL abort_reach got=%0d exp=3", n + 1); end
    if (hit) begin
      checks++; if (rx_data !== 8'h43) begin failures++; $display("FAIL abort_third got=%0h exp=43", rx_data); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%0b exp=0", rx_valid); end
      checks++; if (active !== 1'b0)   begin failures++; $display("FAIL abort_active got=%0b exp=0", active); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL abort_char got=%0h exp=%0h", g, e); end
    end
    exp_q.delete();
    download(str2q("X"));
    collect(1, 500);
    checks++; if (timed_out || got_q.size() != 1) begin failures++; $display("FAIL redl_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL redl_char got=%0h exp=%0h", g, e); end
    end
  endtask

  task automatic test_restart();
    int cyc;
    logic [7:0] g, e;
    exp_q.delete();
    download(str2q("PQ"));
    cyc = 0;
    while (!rx_valid && cyc < 100) begin tick(); cyc++; end
    checks++; if (rx_data !== 8'h50 || rx_valid !== 1'b1) begin failures++; $display("FAIL restart_first got=%0h exp=50", rx_data); end
    abort = 1'b1; ioctl_download = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (active !== 1'b0)   begin failures++; $display("FAIL restart_active got=%0b exp=0", active); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL restart_valid got=%0b exp=0", rx_valid); end
    exp_q.delete();
    download(str2q("Y"));
    collect(0, 500);
    checks++; if (timed_out || got_q.size() != 1) begin failures++; $display("FAIL restart_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL restart_char got=%0h exp=%0h", g, e); end
    end
  endtask

  task automatic test_reset_mid_gap();
    int cyc;
    exp_q.delete();
    download(str2q("AB"));
    cyc = 0;
    while (!rx_valid && cyc < 100) begin tick(); cyc++; end
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL midgap_pre_active got=%0b exp=1", active); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midgap_rx_data got=%0h exp=0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midgap_rx_valid got=%0b exp=0", rx_valid); end
    checks++; if (active !== 1'b0)   begin failures++; $display("FAIL midgap_active got=%0b exp=0", active); end
    #2 n_reset = 1'b1;
    repeat (5) tick();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midgap_stays_idle got=%0b exp=0", active); end
    exp_q.delete();
  endtask

  task automatic test_full();
    int cyc, bad_byte, bad_gap, last;
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < DEPTH; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = ADDR_W'(i); ioctl_data = 8'h5A; tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; tick();
    cyc = 0;
    while (!active && cyc < 20) begin tick(); cyc++; end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL full_prefill_abort got=%0b exp=0", active); end

    ioctl_download = 1'b1; tick();
    ioctl_wr = 1'b1; ioctl_addr = ADDR_W'(DEPTH - 1); ioctl_data = 8'h51; tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0; tick();
    collect(0, 60000);
    last = got_q.size() - 1;
    checks++; if (timed_out) begin failures++; $display("FAIL full_timeout got=active exp=idle"); end
    checks++; if (got_q.size() != DEPTH) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), DEPTH); end
    if (last >= 0) begin
      checks++; if (got_q[last] !== 8'h51) begin failures++; $display("FAIL full_last got=%0h exp=51", got_q[last]); end
    end
    bad_byte = 0; bad_gap = 0;
    for (int i = 0; i < last; i++) if (got_q[i] !== 8'h5A) bad_byte++;
    for (int i = 0; i < gap_q.size(); i++)
      if (gap_q[i] != ((i == gap_q.size() - 1) ? CHAR_GAP + 1 : CHAR_GAP + 3)) bad_gap++;
    checks++; if (bad_byte != 0)  begin failures++; $display("FAIL full_bytes got=%0d exp=0", bad_byte); end
    checks++; if (bad_gap != 0)   begin failures++; $display("FAIL full_gaps got=%0d exp=0", bad_gap); end
    checks++; if (bad_clear != 0) begin failures++; $display("FAIL full_valid_clear got=%0d exp=0", bad_clear); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eof();
    test_empty();
    test_abort();
    test_restart();
    test_reset_mid_gap();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
